dmem_arbiter: RTL and testbench

//  Shares the single data-memory port (MemRead/MemWrite/a/wd/Funct3/rd) between two requesters:

---
 rtl/dmem_arb_pkg.sv | 36 +++
 rtl/arb2_rr.sv | 54 +++++
 rtl/dmem_arbiter.sv | 88 ++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Purpose : shared types and constants for the two-port data-memory arbiter.
// Latency : n/a (definitions only).
// Backpressure: n/a.
//
// Contents: port indices, RISC-V load/store funct3 codes, and the M-stage
// command record carried from the accept cycle to the memory cycle.
package dmem_arb_pkg;

    localparam int PORT_CORE = 0;
    localparam int PORT_DMA  = 1;

    // Loads
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Stores
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Field widths of the M-stage record; the top-level DM_ADDRESS/DATA_W
    // parameters default to these and must be kept equal to them.
    localparam int CMD_ADDR_W = 9;
    localparam int CMD_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
        logic                  owner;
    } dmem_cmd_t;

endpackage

// File: rtl/arb2_rr.sv
// Purpose : two-way grant logic, round-robin or port-0 priority with starvation guard.
// Latency : grant is combinational from valid in the same cycle.
// Backpressure: a port that is valid but not granted simply waits; no internal queueing.
//
// Ports: clk, rst_n (sync, active low), valid[1:0] in; grant[1:0] out (one-hot or zero,
// only ever set on a valid port).
module arb2_rr #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic             last_p1;     // 1 = port 1 was granted most recently
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (FIXED_PRIO) grant = starved ? 2'b10 : 2'b01;
                else            grant = last_p1 ? 2'b01 : 2'b10;
            end
            default: grant = 2'b00;
        endcase
    end

    // A grant always transfers (grant is only given to a valid port), so the
    // pointer moves whenever any grant is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_p1    <= 1'b1;
            starve_cnt <= '0;
        end else begin
            if (|grant) last_p1 <= grant[1];
            if (valid[1] && !grant[1]) begin
                if (!starved) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose : shares one data-memory port between the core LSU (port 0) and DMA/debug (port 1).
// Latency : fixed 2 cycles request-accept to rsp_valid; one access per cycle.
// Backpressure: req_ready withholds the losing port; responses cannot be stalled.
//
// Ports: clk, rst_n (sync, active low); per-port req_valid/req_ready/req_we/req_addr/
// req_wdata/req_funct3; per-port rsp_valid pulse with shared rsp_rdata; memory side
// MemRead/MemWrite/a/wd/Funct3 out, rd in (combinational read data).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = CMD_ADDR_W,
    parameter int DATA_W     = CMD_DATA_W,
    parameter bit FIXED_PRIO = 1'b0,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_we,
    input  logic [1:0][DM_ADDRESS-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0]     req_wdata,
    input  logic [1:0][2:0]            req_funct3,
    output logic [1:0]                 rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       MemRead,
    output logic                       MemWrite,
    output logic [DM_ADDRESS-1:0]      a,
    output logic [DATA_W-1:0]          wd,
    output logic [2:0]                 Funct3,
    input  logic [DATA_W-1:0]          rd
);

    logic [1:0] grant;
    logic       xfer;
    logic       sel;
    dmem_cmd_t  cmd_in;
    dmem_cmd_t  m_cmd;
    logic       m_vld;

    arb2_rr #(
        .FIXED_PRIO (FIXED_PRIO),
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .grant (grant)
    );

    // Ready is gated by reset so nothing is accepted while the pipe is being cleared.
    assign req_ready = req_valid & grant & {2{rst_n}};
    assign xfer      = |req_ready;
    assign sel       = req_ready[PORT_DMA];

    always_comb begin
        cmd_in        = '0;
        cmd_in.we     = req_we[sel];
        cmd_in.addr   = req_addr[sel];
        cmd_in.wdata  = req_wdata[sel];
        cmd_in.funct3 = req_funct3[sel];
        cmd_in.owner  = sel;
    end

    // M stage holds zeros on a bubble so the memory outputs idle at 0 without extra muxing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_vld     <= 1'b0;
            m_cmd     <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
        end else begin
            m_vld     <= xfer;
            m_cmd     <= xfer ? cmd_in : '0;
            rsp_valid <= 2'b00;
            if (m_vld) rsp_valid[m_cmd.owner] <= 1'b1;
            // Store responses and bubbles return zero data.
            rsp_rdata <= (m_vld && !m_cmd.we) ? rd : '0;
        end
    end

    assign MemRead  = m_vld & ~m_cmd.we;
    assign MemWrite = m_vld &  m_cmd.we;
    assign a        = m_cmd.addr;
    assign wd       = m_cmd.wdata;
    assign Funct3   = m_cmd.funct3;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed self-checking bench for dmem_arbiter (round-robin and fixed-priority builds).
// Latency : checks the 2-cycle accept-to-response timing and memory-side cycle.
// Backpressure: exercises contention, starvation guard, reset flush and idle behaviour.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk;
    logic rst_n;

    // Round-robin instance
    logic [1:0]       r_valid, r_ready, r_we, r_rsp_valid;
    logic [1:0][8:0]  r_addr;
    logic [1:0][31:0] r_wdata;
    logic [1:0][2:0]  r_funct3;
    logic [31:0]      r_rsp_rdata, r_wd, r_rd;
    logic             r_MemRead, r_MemWrite;
    logic [8:0]       r_a;
    logic [2:0]       r_Funct3;

    // Fixed-priority instance (STARVE_MAX=3)
    logic [1:0]       f_valid, f_ready, f_we, f_rsp_valid;
    logic [1:0][8:0]  f_addr;
    logic [1:0][31:0] f_wdata;
    logic [1:0][2:0]  f_funct3;
    logic [31:0]      f_rsp_rdata, f_wd, f_rd;
    logic             f_MemRead, f_MemWrite;
    logic [8:0]       f_a;
    logic [2:0]       f_Funct3;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_r [0:127];

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .FIXED_PRIO(1'b0), .STARVE_MAX(8)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r_valid), .req_ready(r_ready), .req_we(r_we), .req_addr(r_addr),
        .req_wdata(r_wdata), .req_funct3(r_funct3),
        .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata),
        .MemRead(r_MemRead), .MemWrite(r_MemWrite), .a(r_a), .wd(r_wd),
        .Funct3(r_Funct3), .rd(r_rd)
    );

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .FIXED_PRIO(1'b1), .STARVE_MAX(3)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(f_valid), .req_ready(f_ready), .req_we(f_we), .req_addr(f_addr),
        .req_wdata(f_wdata), .req_funct3(f_funct3),
        .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
        .MemRead(f_MemRead), .MemWrite(f_MemWrite), .a(f_a), .wd(f_wd),
        .Funct3(f_Funct3), .rd(f_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: write on falling edge, combinational word read.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) mem_r[i] <= 32'h0;
            mem_r[4] <= 32'hDEADBEEF;   // byte address 0x010
            mem_r[5] <= 32'hCAFEF00D;   // byte address 0x014
        end else if (r_MemWrite) begin
            mem_r[r_a[8:2]] <= r_wd;
        end
    end
    assign r_rd = r_MemRead ? mem_r[r_a[8:2]] : 32'h0;
    assign f_rd = 32'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0] rr_exp [4];
    logic [1:0] fp_exp [8];

    initial begin
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        fp_exp = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

        rst_n    = 1'b0;
        r_valid  = 2'b01;   // valid during reset must not be accepted
        r_we     = 2'b00;
        r_addr   = '0;
        r_wdata  = '0;
        r_funct3 = '0;
        f_valid  = 2'b00;
        f_we     = 2'b00;
        f_addr   = '0;
        f_wdata  = '0;
        f_funct3 = '0;

        // ---- Reset state ----
        tick; tick;
        #1;
        chk("reset_ready",   r_ready, 2'b00);
        chk("reset_rsp",     {r_rsp_valid, r_rsp_rdata}, 34'h0);
        chk("reset_memctl",  {r_MemRead, r_MemWrite, r_a, r_Funct3}, 14'h0);
        chk("reset_wd",      r_wd, 32'h0);
        chk("reset_f_out",   {f_ready, f_rsp_valid, f_MemRead, f_MemWrite}, 6'h0);

        tick;
        rst_n   = 1'b1;
        r_valid = 2'b00;

        // ---- Round-robin: both valid, grants 0,1,0,1 ----
        r_addr[0]   = 9'h010;
        r_addr[1]   = 9'h014;
        r_funct3[0] = F3_LW;
        r_funct3[1] = F3_LW;
        for (int k = 0; k < 6; k++) begin
            tick;
            r_valid = (k < 4) ? 2'b11 : 2'b00;
            #1;
            chk("rr_ready", r_ready, (k < 4) ? rr_exp[k] : 2'b00);
            if (k >= 1 && k < 5)
                chk("rr_addr", r_a, (rr_exp[k-1] == 2'b01) ? 9'h010 : 9'h014);
            if (k >= 2) begin
                chk("rr_rsp_owner", r_rsp_valid, rr_exp[k-2]);
                chk("rr_rsp_data", r_rsp_rdata,
                    (rr_exp[k-2] == 2'b01) ? 32'hDEADBEEF : 32'hCAFEF00D);
            end else begin
                chk("rr_rsp_early", r_rsp_valid, 2'b00);
            end
        end

        // ---- Fixed priority, STARVE_MAX=3: grants 0,0,0,1,0,0,0,1 ----
        f_addr[0] = 9'h040;
        f_addr[1] = 9'h044;
        for (int k = 0; k < 10; k++) begin
            tick;
            f_valid = (k < 8) ? 2'b11 : 2'b00;
            #1;
            chk("fp_ready", f_ready, (k < 8) ? fp_exp[k] : 2'b00);
            if (k >= 2) chk("fp_rsp_owner", f_rsp_valid, fp_exp[k-2]);
        end

        // ---- Single load port 0 @0x010 ----
        tick;
        r_valid     = 2'b01;
        r_we        = 2'b00;
        r_addr[0]   = 9'h010;
        r_funct3[0] = F3_LW;
        #1;
        chk("ld_ready_n", r_ready, 2'b01);
        tick;
        r_valid = 2'b00;
        #1;
        chk("ld_mem_n1", {r_MemRead, r_MemWrite, r_a, r_Funct3}, {1'b1, 1'b0, 9'h010, F3_LW});
        chk("ld_rsp_n1", r_rsp_valid, 2'b00);
        tick;
        chk("ld_rsp_n2", {r_rsp_valid, r_rsp_rdata}, {2'b01, 32'hDEADBEEF});
        chk("ld_mem_n2", {r_MemRead, r_MemWrite}, 2'b00);
        tick;
        chk("ld_rsp_n3", r_rsp_valid, 2'b00);

        // ---- RAW: p1 SW @0x020 then p0 LW @0x020 ----
        tick;
        r_valid     = 2'b10;
        r_we        = 2'b10;
        r_addr[1]   = 9'h020;
        r_wdata[1]  = 32'h12345678;
        r_funct3[1] = F3_SW;
        #1;
        chk("raw_st_ready", r_ready, 2'b10);
        tick;
        r_valid     = 2'b01;
        r_we        = 2'b00;
        r_addr[0]   = 9'h020;
        r_funct3[0] = F3_LW;
        #1;
        chk("raw_ld_ready", r_ready, 2'b01);
        chk("raw_st_mem", {r_MemRead, r_MemWrite, r_a, r_Funct3}, {1'b0, 1'b1, 9'h020, F3_SW});
        chk("raw_st_wd", r_wd, 32'h12345678);
        tick;
        r_valid = 2'b00;
        #1;
        chk("raw_st_rsp", {r_rsp_valid, r_rsp_rdata}, {2'b10, 32'h0});
        chk("raw_ld_mem", {r_MemRead, r_MemWrite, r_a}, {1'b1, 1'b0, 9'h020});
        tick;
        chk("raw_ld_rsp", {r_rsp_valid, r_rsp_rdata}, {2'b01, 32'h12345678});

        // ---- Reset mid-operation ----
        tick;
        r_valid   = 2'b01;
        r_addr[0] = 9'h010;
        #1;
        chk("rst_acc_ready", r_ready, 2'b01);
        tick;
        rst_n = 1'b0;
        #1;
        chk("rst_gate_ready", r_ready, 2'b00);
        tick;
        rst_n   = 1'b1;
        r_valid = 2'b00;
        #1;
        chk("rst_no_rsp", {r_rsp_valid, r_rsp_rdata}, 34'h0);
        chk("rst_memctl", {r_MemRead, r_MemWrite, r_a, r_Funct3}, 14'h0);
        chk("rst_wd", r_wd, 32'h0);
        tick;
        chk("rst_no_rsp_late", r_rsp_valid, 2'b00);

        // ---- Idle with toggling payload ----
        for (int k = 0; k < 10; k++) begin
            tick;
            r_valid  = 2'b00;
            r_we     = 2'($urandom_range(0, 3));
            r_addr   = 18'($urandom);
            r_wdata  = {$urandom, $urandom};
            r_funct3 = 6'($urandom);
            #1;
            chk("idle_outputs", {r_MemRead, r_MemWrite, r_ready, r_rsp_valid}, 6'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
